// File: rtl/cmd_arb_if.sv
// Command handshake bundle: requester -> arbiter and arbiter -> cmd_cfg.
// master issues cmd_rdy/cmd/data; slave returns clr_cmd_rdy/resp/send_resp.
interface cmd_arb_if;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;

  modport master (output cmd_rdy, cmd, data, input clr_cmd_rdy, resp, send_resp);
  modport slave  (input cmd_rdy, cmd, data, output clr_cmd_rdy, resp, send_resp);
endinterface

// File: rtl/cmd_arb.sv
// Round-robin arbiter sharing the cmd_cfg port between remote and local requesters.
// Define LINK_WDOG_EN to add the link-loss watchdog that injects EMER_LAND.
module cmd_arb #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  cmd_arb_if.slave  rmt,
  cmd_arb_if.slave  loc,
  cmd_arb_if.master cfg,
  output logic      owner,
  output logic      link_lost
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  localparam logic [26:0] WD_LIMIT = FAST_SIM ? 27'd4096 : 27'd67108864;

  state_t      state;
  logic        cmd_rdy_q;
  logic [7:0]  cmd_q;
  logic [15:0] data_q;
  logic        last_srv;   // 1 = local served last
  logic        emer_own;   // current transaction is the internal EMER_LAND
  logic        emer_req;
  logic        pick, grant, rmt_grant, emer_grant;
  logic        fwd_clr, fwd_send;

  always_comb begin
    pick = 1'b0;
    if (rmt.cmd_rdy && loc.cmd_rdy) pick = ~last_srv;
    else if (loc.cmd_rdy)           pick = 1'b1;
  end

  assign emer_grant = (state == IDLE) && emer_req;
  assign grant      = (state == IDLE) && !emer_req && (rmt.cmd_rdy || loc.cmd_rdy);
  assign rmt_grant  = grant && !pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_rdy_q <= 1'b0;
      cmd_q     <= 8'h00;
      data_q    <= 16'h0000;
      owner     <= 1'b0;
      last_srv  <= 1'b1;
      emer_own  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (emer_grant) begin
            cmd_q     <= 8'h07;
            data_q    <= 16'h0000;
            emer_own  <= 1'b1;
            cmd_rdy_q <= 1'b1;
            state     <= ISSUE;
          end else if (grant) begin
            cmd_q     <= pick ? loc.cmd  : rmt.cmd;
            data_q    <= pick ? loc.data : rmt.data;
            owner     <= pick;
            last_srv  <= pick;
            emer_own  <= 1'b0;
            cmd_rdy_q <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cfg.clr_cmd_rdy) begin
            cmd_rdy_q <= 1'b0;
            state     <= cfg.send_resp ? IDLE : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (cfg.send_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cfg.cmd_rdy = cmd_rdy_q;
  assign cfg.cmd     = cmd_q;
  assign cfg.data    = data_q;

  // Ack/response routing is combinational so the owner sees them in the cmd_cfg cycle.
  assign fwd_clr  = (state == ISSUE) && cfg.clr_cmd_rdy && !emer_own;
  assign fwd_send = !emer_own && cfg.send_resp &&
                    (((state == ISSUE) && cfg.clr_cmd_rdy) || (state == WAIT_RESP));

  assign rmt.clr_cmd_rdy = fwd_clr && !owner;
  assign loc.clr_cmd_rdy = fwd_clr && owner;
  assign rmt.send_resp   = fwd_send && !owner;
  assign loc.send_resp   = fwd_send && owner;
  assign rmt.resp        = (fwd_send && !owner) ? cfg.resp : 8'h00;
  assign loc.resp        = (fwd_send && owner)  ? cfg.resp : 8'h00;

`ifdef LINK_WDOG_EN
  logic [26:0] wd_cnt;
  logic        emer_pend;

  // Counter saturates at the limit so EMER_LAND is posted once per loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      link_lost <= 1'b0;
      emer_pend <= 1'b0;
    end else begin
      if (rmt_grant) begin
        wd_cnt    <= '0;
        link_lost <= 1'b0;
      end else if (wd_cnt == WD_LIMIT - 27'd1) begin
        wd_cnt    <= WD_LIMIT;
        link_lost <= 1'b1;
        emer_pend <= 1'b1;
      end else if (wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + 27'd1;
      end
      if (emer_grant) emer_pend <= 1'b0;
    end
  end

  assign emer_req = emer_pend;
`else
  logic unused_wdog;

  assign link_lost   = 1'b0;
  assign emer_req    = 1'b0;
  assign unused_wdog = rmt_grant ^ WD_LIMIT[12];
`endif
endmodule
